// File: rtl/tx_sequencer.sv
// tx_sequencer: serialises a frame (preamble, sync, 2-byte length, RAM payload) MSB first.
// Ports:
//   clk, reset          posedge clock, asynchronous active-high reset
//   i_transmit          transmit request level; a frame starts on its rising edge
//   i_msg_length        payload byte count, sampled on the start edge, clamped to MAX_LEN
//   o_ram_rd/o_ram_addr payload RAM read strobe and address (address holds between reads)
//   i_ram_data          RAM data, valid one cycle after o_ram_rd
//   o_bit/o_bit_valid   serial bit stream, transferred when o_bit_valid & i_bit_ready
//   i_bit_ready         modulator ready
//   o_tx_active         high while a frame is on the wire
//   o_tx_done           one-cycle completion pulse
module tx_sequencer #(
    parameter int         PREAMBLE_LEN = 4,
    parameter logic [7:0] SYNC_WORD    = 8'h2D,
    parameter logic [9:0] MAX_LEN      = 10'd1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_transmit,
    input  logic [9:0] i_msg_length,
    output logic       o_ram_rd,
    output logic [9:0] o_ram_addr,
    input  logic [7:0] i_ram_data,
    output logic       o_bit,
    output logic       o_bit_valid,
    input  logic       i_bit_ready,
    output logic       o_tx_active,
    output logic       o_tx_done
);
    typedef enum logic [3:0] {IDLE, PREAMBLE, SYNC, LEN_HI, LEN_LO, FETCH, WAIT_RAM, PAYLOAD, DONE} state_t;
    state_t state, next_state;
    logic [7:0] shift, load_byte;
    logic [9:0] len, len_in;
    logic [3:0] pre_cnt;
    logic [2:0] bit_cnt;
    logic load, transmit_d, armed, start, transfer, last_bit;
    assign len_in   = (i_msg_length > MAX_LEN) ? MAX_LEN : i_msg_length;
    // armed stays low after reset until i_transmit is seen low, so a request
    // already high at reset release cannot masquerade as a rising edge
    assign start    = i_transmit & ~transmit_d & armed;
    assign transfer = o_bit_valid & i_bit_ready;
    assign last_bit = transfer & (bit_cnt == 3'd0);
    assign o_bit    = shift[7];
    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_byte  = 8'hAA;
        case (state)
            IDLE: if (start) begin
                next_state = (len_in == 10'd0) ? DONE : PREAMBLE;
                load       = len_in != 10'd0;
            end
            PREAMBLE: if (last_bit) begin
                load = 1'b1;
                if (pre_cnt == 4'(PREAMBLE_LEN - 1)) begin
                    next_state = SYNC;
                    load_byte  = SYNC_WORD;
                end
            end
            SYNC: if (last_bit) begin
                next_state = LEN_HI;
                load       = 1'b1;
                load_byte  = {6'b0, len[9:8]};
            end
            LEN_HI: if (last_bit) begin
                next_state = LEN_LO;
                load       = 1'b1;
                load_byte  = len[7:0];
            end
            LEN_LO:   next_state = last_bit ? FETCH : LEN_LO;
            FETCH:    next_state = WAIT_RAM;
            WAIT_RAM: begin
                next_state = PAYLOAD;
                load       = 1'b1;
                load_byte  = i_ram_data;
            end
            PAYLOAD: if (last_bit) next_state = (o_ram_addr == len - 10'd1) ? DONE : FETCH;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= 8'h00;
            len         <= 10'd0;
            pre_cnt     <= 4'd0;
            bit_cnt     <= 3'd0;
            transmit_d  <= 1'b0;
            armed       <= 1'b0;
            o_ram_rd    <= 1'b0;
            o_ram_addr  <= 10'd0;
            o_bit_valid <= 1'b0;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            state      <= next_state;
            transmit_d <= i_transmit;
            armed      <= armed | ~i_transmit;
            if (state == IDLE && start) begin
                len     <= len_in;
                pre_cnt <= 4'd0;
                bit_cnt <= 3'd7;
            end else if (transfer) begin
                bit_cnt <= bit_cnt - 3'd1;
            end
            if (state == PREAMBLE && last_bit) pre_cnt <= pre_cnt + 4'd1;
            shift <= load ? load_byte : transfer ? {shift[6:0], 1'b0} : shift;
            // o_ram_addr doubles as the payload byte index
            if (next_state == FETCH) o_ram_addr <= (state == LEN_LO) ? 10'd0 : o_ram_addr + 10'd1;
            o_ram_rd    <= next_state == FETCH;
            o_bit_valid <= next_state inside {PREAMBLE, SYNC, LEN_HI, LEN_LO, PAYLOAD};
            o_tx_active <= next_state != IDLE && next_state != DONE;
            o_tx_done   <= next_state == DONE;
        end
    end
endmodule
